vga_timing_gen: RTL

- Parametrised VGA raster timing generator. It is the timing core split out of the Tetris display path.
- Produces pixel-clock enable, hsync/vsync, data-enable, raster coordinates and frame/line strobes from the 100 MHz system clock.
- Downstream board/sprite renderers consume x/y and must present rgb aligned to the delayed de/hsync/vsync.
- Generalises the fixed 640x480 timing with programmable porches, polarities, clock division and sync-delay alignment.

---
 rtl/vga_timing_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator. Derives a pixel-slot
//               strobe from the system clock, runs the x/y raster counters,
//               decodes active video and sync pulses, and delays those through
//               an optional pixel-slot pipeline so renderers can align rgb.
// Ports       : clk         - system clock
//               rst_n       - asynchronous active-low reset
//               en          - synchronous run enable (0 forces idle state)
//               pix_ce      - one-clk pixel-slot strobe
//               x, y        - current raster coordinate (not delayed)
//               de          - active-video flag, 1+SYNC_DELAY slots behind x/y
//               hsync/vsync - sync outputs, same latency as de
//               line_start  - one-clk pulse in the cycle x becomes 0
//               frame_start - one-clk pulse in the cycle (x,y) becomes (0,0)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int CLK_DIV    = 4,
    parameter int SYNC_DELAY = 0,
    parameter int CNT_W      = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             pix_ce,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             c_HS_IDLE  = ~HS_POL;
    localparam logic             c_VS_IDLE  = ~VS_POL;

    // Reject geometries that cannot be represented or make no sense.
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CLK_DIV < 1 || SYNC_DELAY < 0 || SYNC_DELAY > 7 || CNT_W < 2 ||
        CNT_W > 30 || H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W))
    begin : g_param_check
        $error("vga_timing_gen: invalid timing parameters");
    end

    logic                  run_q;
    logic [DIV_W-1:0]      div_q,  div_d;
    logic [CNT_W-1:0]      x_q,    x_d;
    logic [CNT_W-1:0]      y_q,    y_d;
    logic                  ls_q,   ls_d;
    logic                  fs_q,   fs_d;
    logic                  de0_d,  hs0_d,  vs0_d;
    // Index 0 is decode stage 0; index SYNC_DELAY drives the outputs.
    logic [SYNC_DELAY:0]   de_pipe_q;
    logic [SYNC_DELAY:0]   hs_pipe_q;
    logic [SYNC_DELAY:0]   vs_pipe_q;

    // run_q delays en by one edge so pix_ce stays low in reset and in the
    // cycle after en rises, giving the first strobe CLK_DIV cycles later.
    assign pix_ce = run_q && (div_q == c_DIV_LAST);

    always_comb begin
        div_d = div_q;
        x_d   = x_q;
        y_d   = y_q;
        ls_d  = 1'b0;
        fs_d  = 1'b0;

        // Decode uses the pre-advance coordinate of this slot.
        de0_d = (x_q < c_H_ACT) && (y_q < c_V_ACT);
        hs0_d = ((x_q >= c_HS_START) && (x_q < c_HS_END)) ? HS_POL : c_HS_IDLE;
        vs0_d = ((y_q >= c_VS_START) && (y_q < c_VS_END)) ? VS_POL : c_VS_IDLE;

        if (!en) begin
            div_d = '0;
            x_d   = '0;
            y_d   = '0;
        end else if (pix_ce) begin
            div_d = '0;
            if (x_q == c_H_LAST) begin
                x_d  = '0;
                ls_d = 1'b1;
                if (y_q == c_V_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + CNT_W'(1);
                end
            end else begin
                x_d = x_q + CNT_W'(1);
            end
        end else if (run_q) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            div_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
            de_pipe_q <= '0;
            hs_pipe_q <= {(SYNC_DELAY + 1){c_HS_IDLE}};
            vs_pipe_q <= {(SYNC_DELAY + 1){c_VS_IDLE}};
        end else begin
            run_q <= en;
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
            if (!en) begin
                de_pipe_q <= '0;
                hs_pipe_q <= {(SYNC_DELAY + 1){c_HS_IDLE}};
                vs_pipe_q <= {(SYNC_DELAY + 1){c_VS_IDLE}};
            end else if (pix_ce) begin
                de_pipe_q[0] <= de0_d;
                hs_pipe_q[0] <= hs0_d;
                vs_pipe_q[0] <= vs0_d;
                for (int i = 1; i <= SYNC_DELAY; i++) begin
                    de_pipe_q[i] <= de_pipe_q[i-1];
                    hs_pipe_q[i] <= hs_pipe_q[i-1];
                    vs_pipe_q[i] <= vs_pipe_q[i-1];
                end
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_pipe_q[SYNC_DELAY];
    assign hsync       = hs_pipe_q[SYNC_DELAY];
    assign vsync       = vs_pipe_q[SYNC_DELAY];
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule
`default_nettype wire
